// File: rtl/player_vertical_motion.sv
// rtl/player_vertical_motion.sv - per-frame vertical physics, line landing and death detection for the player sprite
module player_vertical_motion #(
    parameter int START_H = 60,
    parameter int GRAV    = 1,
    parameter int VMAX    = 8,
    parameter int FLOOR_H = 420,
    parameter int CEIL_H  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       dir,
    input  logic [2:0] lines,
    output logic [8:0] height,
    output logic [3:0] vel,
    output logic       grounded,
    output logic       is_dead
);

    // Encoding chosen so grounded and is_dead are single state flop bits.
    typedef enum logic [1:0] {
        AIRBORNE = 2'b00,
        GROUNDED = 2'b01,
        DEAD     = 2'b10
    } state_t;

    localparam logic [8:0] REST_DN0 = 9'd120;
    localparam logic [8:0] REST_DN1 = 9'd240;
    localparam logic [8:0] REST_UP1 = 9'd180;
    localparam logic [8:0] REST_UP2 = 9'd300;

    localparam logic signed [10:0] REST_DN0_S = 11'sd120;
    localparam logic signed [10:0] REST_DN1_S = 11'sd240;
    localparam logic signed [10:0] REST_UP1_S = 11'sd180;
    localparam logic signed [10:0] REST_UP2_S = 11'sd300;
    localparam logic signed [10:0] FLOOR_S    = 11'(FLOOR_H);
    localparam logic signed [10:0] CEIL_S     = 11'(CEIL_H);

    localparam logic [4:0] GRAV_W  = 5'(GRAV);
    localparam logic [4:0] VMAX_W  = 5'(VMAX);
    localparam logic [8:0] START_W = 9'(START_H);
    localparam logic [8:0] FLOOR_W = 9'(FLOOR_H);
    localparam logic [8:0] CEIL_W  = 9'(CEIL_H);

    state_t            state, state_next;
    logic [8:0]        height_next;
    logic [3:0]        vel_next;

    logic [4:0]        v_sum;
    logic [3:0]        v_new;
    logic signed [10:0] h_s;
    logic signed [10:0] v_s;
    logic signed [10:0] cand;
    logic              at_rest;
    logic              snap_hit;
    logic [8:0]        snap_h;

    // Candidate position is widened and signed so a rise past row 0 stays negative.
    always_comb begin
        v_sum = {1'b0, vel} + GRAV_W;
        v_new = (v_sum > VMAX_W) ? VMAX_W[3:0] : v_sum[3:0];
        h_s   = signed'({2'b00, height});
        v_s   = signed'({7'b0000000, v_new});
        cand  = dir ? (h_s - v_s) : (h_s + v_s);
    end

    // Exact arrival on a rest point is a plain move; only a strict overshoot snaps.
    always_comb begin
        at_rest  = 1'b0;
        snap_hit = 1'b0;
        snap_h   = height;
        if (!dir) begin
            at_rest = (lines[0] && height == REST_DN0) || (lines[1] && height == REST_DN1);
            if (lines[0] && height < REST_DN0 && cand > REST_DN0_S) begin
                snap_hit = 1'b1;
                snap_h   = REST_DN0;
            end else if (lines[1] && height < REST_DN1 && cand > REST_DN1_S) begin
                snap_hit = 1'b1;
                snap_h   = REST_DN1;
            end
        end else begin
            at_rest = (lines[1] && height == REST_UP1) || (lines[2] && height == REST_UP2);
            if (lines[2] && height > REST_UP2 && cand < REST_UP2_S) begin
                snap_hit = 1'b1;
                snap_h   = REST_UP2;
            end else if (lines[1] && height > REST_UP1 && cand < REST_UP1_S) begin
                snap_hit = 1'b1;
                snap_h   = REST_UP1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= AIRBORNE;
            height <= START_W;
            vel    <= 4'd0;
        end else begin
            state  <= state_next;
            height <= height_next;
            vel    <= vel_next;
        end
    end

    always_comb begin
        state_next  = state;
        height_next = height;
        vel_next    = vel;
        if (tick) begin
            case (state)
                AIRBORNE: begin
                    if (at_rest) begin
                        state_next = GROUNDED;
                        vel_next   = 4'd0;
                    end else if (snap_hit) begin
                        state_next  = GROUNDED;
                        height_next = snap_h;
                        vel_next    = 4'd0;
                    end else if (!dir && cand >= FLOOR_S) begin
                        state_next  = DEAD;
                        height_next = FLOOR_W;
                        vel_next    = v_new;
                    end else if (dir && cand <= CEIL_S) begin
                        state_next  = DEAD;
                        height_next = CEIL_W;
                        vel_next    = v_new;
                    end else begin
                        height_next = cand[8:0];
                        vel_next    = v_new;
                    end
                end
                GROUNDED: begin
                    if (!at_rest) begin
                        state_next = AIRBORNE;
                        vel_next   = 4'd0;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_comb begin
        grounded = (state == GROUNDED);
        is_dead  = (state == DEAD);
    end

endmodule
